xadc_drp_sequencer: RTL and testbench
=====================================

// Module: xadc_drp_sequencer
// PURPOSE
//  Owns the XADC DRP port. Each XADC end-of-conversion starts a scan that reads
//  NUM_CH channel registers and publishes them as 16-bit samples with valid
//  strobes, for the VGA plotter and other consumers. Shares the DRP with one
//  host write requester (config registers), arbitrated at scan boundaries.
//  Sits between the XADC wizard instance and all sample consumers.
// PARAMETERS
//  NUM_CH    2                   number of channels read per scan (1..8)
//  CH_ADDRS  {7'h03, 7'h16}      packed NUM_CH*7 DRP addrs; slot i = bits [7i+6:7i]
//  TIMEOUT   255                 max cycles waiting for drp_drdy before abort (>=4)
// PORTS
//  clk           in   1          system clock (100 MHz, same as XADC dclk_in)
//  rst           in   1          asynchronous, active-high reset
//  eoc_in        in   1          XADC eoc_out pulse
//  drp_den       out  1          DRP enable, one-cycle pulse
//  drp_dwe       out  1          DRP write enable, high only with drp_den on writes
//  drp_daddr     out  7          DRP address
//  drp_di        out  16         DRP write data
//  drp_do        in   16         DRP read data, valid with drp_drdy
//  drp_drdy      in   1          DRP ready
//  wr_req        in   1          host write request, held until wr_ack
//  wr_addr       in   7          host write address, stable while wr_req
//  wr_data       in   16         host write data, stable while wr_req
//  wr_ack        out  1          one-cycle pulse: host write finished (or timed out)
//  sample        out  NUM_CH*16  latest sample per channel, slot i = [16i+15:16i]
//  sample_valid  out  NUM_CH     one-cycle pulse per slot when its sample updates
//  scan_done     out  1          one-cycle pulse after last channel of a scan
//  timeout_err   out  1          sticky; set on any DRP timeout
//  err_clr       in   1          clears timeout_err (set wins if same cycle)
// BEHAVIOUR
//  Reset: all outputs 0, sample = 0, FSM=IDLE, scan_pending=0, counters 0.
//  Reset mid-transaction abandons it; no wr_ack is issued.
//  All outputs registered. States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
//  scan_pending: set by eoc_in, cleared on IDLE->RD_REQ. eoc_in during a scan
//  re-sets it, so back-to-back eocs coalesce to at most one queued scan.
//  IDLE: wr_req wins -> WR_REQ; else scan_pending -> RD_REQ with ch=0.
//  A scan is never interrupted. A write waits at most one scan.
//  RD_REQ (1 cycle): drp_den=1, drp_dwe=0, daddr=CH_ADDRS[ch] -> RD_WAIT.
//  RD_WAIT on drdy: sample[ch]<=drp_do, sample_valid[ch] pulses next cycle.
//   If ch==NUM_CH-1: scan_done pulses with the last valid -> IDLE.
//   Else ch++ -> RD_REQ.
//  WR_REQ (1 cycle): den=1, dwe=1, daddr=wr_addr, di=wr_data -> WR_WAIT.
//  WR_WAIT on drdy: wr_ack next cycle -> IDLE.
//  Timing: eoc_in at cycle 0 -> den at cycle 2. drdy at cycle k -> valid at
//  k+1 and next den at k+1.
//  Timeout: wait counter resets on entering *_WAIT. When it reaches TIMEOUT
//  with no drdy: timeout_err<=1, abort the transaction.
//   Read: slot keeps its old sample, no valid; continue with the next channel.
//   Write: wr_ack still pulses.
//  drdy outside *_WAIT is ignored. drp_di = 0 and dwe = 0 except in WR_REQ.
// STRUCTURE
//  xadc_pkg: state enum typedef; DRP address constants
//   (ADDR_TEMP=7'h00, ADDR_VCCINT=7'h01, ADDR_VAUX6=7'h16, ADDR_CFG0=7'h40).
//  No sub-module: the FSM, wait counter and capture regs live in one block.
// TESTING (DRP slave model: drdy N cycles after den, programmable/never)
//  1. eoc pulse, drdy latency 3, do=16'h8000 then 16'h1234:
//     daddr 16 then 03; sample={1234,8000}; valid 01 then 10; scan_done once.
//  2. Two eocs 5 cycles apart during a scan -> exactly one follow-on scan,
//     4 den pulses total.
//  3. wr_req (addr 40, data 1234) asserted mid-scan -> scan completes first,
//     then den+dwe with daddr=40, di=1234; wr_ack 1 cycle after drdy.
//  4. wr_req and eoc in the same cycle from IDLE -> write first, then scan.
//  5. Slave never answers ch0 -> timeout_err at TIMEOUT+; ch1 still read.
//     sample[0] unchanged; err_clr clears the flag.
//  6. Assert rst during RD_WAIT -> all outputs 0 immediately. A late drdy
//     after release is ignored; the next eoc scans normally.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and DRP address constants for the XADC DRP sequencer.
package xadc_pkg;

   localparam int unsigned DRP_AW = 7;
   localparam int unsigned DRP_DW = 16;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4
   } drp_state_t;

   // Commonly used XADC DRP register addresses
   localparam logic [DRP_AW-1:0] ADDR_TEMP   = 7'h00;
   localparam logic [DRP_AW-1:0] ADDR_VCCINT = 7'h01;
   localparam logic [DRP_AW-1:0] ADDR_VAUX6  = 7'h16;
   localparam logic [DRP_AW-1:0] ADDR_CFG0   = 7'h40;

endpackage

// File: rtl/xadc_drp_sequencer.sv
// Owns the XADC DRP port: scans NUM_CH channel registers on every end-of-conversion
// and interleaves host register writes between scans.
module xadc_drp_sequencer
   import xadc_pkg::*;
#(
   parameter int unsigned                NUM_CH   = 2,
   parameter logic [NUM_CH*DRP_AW-1:0]   CH_ADDRS = {7'h03, ADDR_VAUX6},
   parameter int unsigned                TIMEOUT  = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     eoc_in,
   output logic                     drp_den,
   output logic                     drp_dwe,
   output logic [DRP_AW-1:0]        drp_daddr,
   output logic [DRP_DW-1:0]        drp_di,
   input  logic [DRP_DW-1:0]        drp_do,
   input  logic                     drp_drdy,
   input  logic                     wr_req,
   input  logic [DRP_AW-1:0]        wr_addr,
   input  logic [DRP_DW-1:0]        wr_data,
   output logic                     wr_ack,
   output logic [NUM_CH*DRP_DW-1:0] sample,
   output logic [NUM_CH-1:0]        sample_valid,
   output logic                     scan_done,
   output logic                     timeout_err,
   input  logic                     err_clr
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   drp_state_t        state;
   logic [CH_W-1:0]   ch;
   logic [CH_W-1:0]   ch_next_c;
   logic [CNT_W-1:0]  wait_cnt;
   logic              scan_pending;
   logic              wait_expired_c;

   // Channel index of the following read and wait-counter expiry
   assign ch_next_c      = ch + CH_W'(1);
   assign wait_expired_c = (wait_cnt == CNT_LIMIT);

   // Sequencer FSM with wait counter, scan bookkeeping and registered DRP/sample outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ch           <= '0;
         wait_cnt     <= '0;
         scan_pending <= 1'b0;
         drp_den      <= 1'b0;
         drp_dwe      <= 1'b0;
         drp_daddr    <= '0;
         drp_di       <= '0;
         wr_ack       <= 1'b0;
         sample       <= '0;
         sample_valid <= '0;
         scan_done    <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         // Strobes default low; a set later in this block overrides err_clr
         drp_den      <= 1'b0;
         drp_dwe      <= 1'b0;
         drp_di       <= '0;
         wr_ack       <= 1'b0;
         sample_valid <= '0;
         scan_done    <= 1'b0;
         if (eoc_in) scan_pending <= 1'b1;
         if (err_clr) timeout_err <= 1'b0;

         unique case (state)
            IDLE: begin
               // wr_ack high means the held request was just serviced
               if (wr_req && !wr_ack) begin
                  state     <= WR_REQ;
                  drp_den   <= 1'b1;
                  drp_dwe   <= 1'b1;
                  drp_daddr <= wr_addr;
                  drp_di    <= wr_data;
               end else if (scan_pending) begin
                  state     <= RD_REQ;
                  ch        <= '0;
                  drp_den   <= 1'b1;
                  drp_daddr <= CH_ADDRS[DRP_AW-1:0];
                  if (!eoc_in) scan_pending <= 1'b0;
               end
            end

            RD_REQ: begin
               state    <= RD_WAIT;
               wait_cnt <= '0;
            end

            RD_WAIT: begin
               if (drp_drdy || wait_expired_c) begin
                  if (drp_drdy) begin
                     sample[DRP_DW*32'(ch) +: DRP_DW] <= drp_do;
                     sample_valid <= NUM_CH'(1) << ch;
                  end else begin
                     timeout_err <= 1'b1;
                  end
                  if (ch == LAST_CH) begin
                     state     <= IDLE;
                     scan_done <= 1'b1;
                  end else begin
                     state     <= RD_REQ;
                     ch        <= ch_next_c;
                     drp_den   <= 1'b1;
                     drp_daddr <= CH_ADDRS[DRP_AW*32'(ch_next_c) +: DRP_AW];
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            WR_REQ: begin
               state    <= WR_WAIT;
               wait_cnt <= '0;
            end

            WR_WAIT: begin
               if (drp_drdy || wait_expired_c) begin
                  if (!drp_drdy) timeout_err <= 1'b1;
                  wr_ack <= 1'b1;
                  state  <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: scan table, directed corner cases,
// randomized traffic against a DRP slave model and a channel-order reference.
module tb_xadc_drp_sequencer;

   localparam int unsigned NUM_CH  = 2;
   localparam int unsigned TIMEOUT = 20;
   localparam logic [13:0] CH_ADDRS = {7'h03, 7'h16};

   logic        clk;
   logic        rst;
   logic        eoc_in;
   logic        drp_den, drp_dwe;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di, drp_do;
   logic        drp_drdy;
   logic        wr_req;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic [31:0] sample;
   logic [1:0]  sample_valid;
   logic        scan_done, timeout_err, err_clr;

   xadc_drp_sequencer #(.NUM_CH(NUM_CH), .CH_ADDRS(CH_ADDRS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .eoc_in(eoc_in),
      .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
      .drp_do(drp_do), .drp_drdy(drp_drdy),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .sample(sample), .sample_valid(sample_valid), .scan_done(scan_done),
      .timeout_err(timeout_err), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] ch_addr(input int i);
      logic [13:0] a;
      a = CH_ADDRS;
      return a[7*i +: 7];
   endfunction

   // DRP slave model: register file, drdy lat cycles after den (0 = never)
   logic [15:0] mem [128];
   int          lat = 3;
   logic [6:0]  never_addr = 7'h7F;
   int          cd = 0;
   logic [6:0]  pa = '0;
   logic        pw = 1'b0;

   initial begin
      drp_drdy = 1'b0;
      drp_do   = '0;
      for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0101);
   end

   always @(posedge clk) begin
      #1;
      drp_drdy = 1'b0;
      drp_do   = 16'hDEAD;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            drp_drdy = 1'b1;
            drp_do   = pw ? 16'h0000 : mem[pa];
         end
      end
      if (drp_den) begin
         if (drp_dwe) mem[drp_daddr] = drp_di;
         pa = drp_daddr;
         pw = drp_dwe;
         cd = (drp_daddr == never_addr) ? 0 : lat;
      end
   end

   // Event counters and reference model (channel order, sample contents)
   int          n_den = 0, n_wden = 0, n_done = 0, n_ack = 0, n_v0 = 0, n_v1 = 0;
   bit          mon_en = 1'b0;
   bit          valid_due = 1'b0;
   bit          out_busy = 1'b0;
   bit          out_rd = 1'b0;
   int          exp_ch = 0;
   logic [31:0] exp_vec = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (drp_den) n_den++;
         if (drp_den && drp_dwe) n_wden++;
         if (scan_done) n_done++;
         if (wr_ack) n_ack++;
         if (sample_valid[0]) n_v0++;
         if (sample_valid[1]) n_v1++;
         if (mon_en) begin
            if (valid_due) begin
               check("rand_valid", 64'(sample_valid), 64'(2'b01 << exp_ch));
               check("rand_sample", 64'(sample), 64'(exp_vec));
               check("rand_done", 64'(scan_done), 64'(exp_ch == NUM_CH - 1));
               exp_ch = (exp_ch + 1) % NUM_CH;
            end else if (sample_valid != 2'b00 || scan_done) begin
               checks++;
               errors++;
               $display("FAIL rand_spurious valid=%b done=%b", sample_valid, scan_done);
            end
            valid_due = 1'b0;
            if (drp_drdy && out_busy) begin
               out_busy = 1'b0;
               if (out_rd) begin
                  exp_vec[16*exp_ch +: 16] = drp_do;
                  valid_due = 1'b1;
               end
            end
            if (drp_den) begin
               if (out_busy) begin
                  checks++;
                  errors++;
                  $display("FAIL rand_overlap den while transaction open addr=%h", drp_daddr);
               end
               if (drp_dwe)
                  check("rand_wr", {drp_daddr, drp_di}, {wr_req, wr_addr, wr_data} & 64'h7FFFFF | 64'h0);
               else
                  check("rand_rd_addr", 64'(drp_daddr), 64'(ch_addr(exp_ch)));
               out_busy = 1'b1;
               out_rd   = !drp_dwe;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_for(input int which, input int max_cyc, input string nm, output int took);
      bit hit;
      hit  = 1'b0;
      took = 0;
      while (!hit && took < max_cyc) begin
         tick();
         took++;
         case (which)
            0:       hit = drp_den;
            1:       hit = drp_den && drp_dwe;
            2:       hit = scan_done;
            3:       hit = wr_ack;
            4:       hit = timeout_err;
            default: hit = 1'b1;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL wait_%s not seen within %0d cycles", nm, max_cyc);
      end
   endtask

   function automatic logic [29:0] ctl_outs();
      return {drp_den, drp_dwe, drp_daddr, drp_di, wr_ack, sample_valid, scan_done, timeout_err};
   endfunction

   task automatic pulse_eoc();
      eoc_in = 1'b1;
      tick();
      eoc_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      eoc_in = 1'b0;
      wr_req = 1'b0;
      err_clr = 1'b0;
      tick(2);
      check("reset_ctl", 64'(ctl_outs()), 64'h0);
      check("reset_sample", 64'(sample), 64'h0);
      rst = 1'b0;
      tick();
   endtask

   typedef struct {
      int          lat;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [31:0] exp_sample;
   } scan_vec_t;

   initial begin
      scan_vec_t vecs [4];
      int        took, snap_done, snap_den, snap_v0, snap_v1, n_wr;
      int        s_den, s_wden, s_done, s_ack;

      vecs[0] = '{3, 16'h8000, 16'h1234, 32'h1234_8000};
      vecs[1] = '{1, 16'hFFFF, 16'h0001, 32'h0001_FFFF};
      vecs[2] = '{5, 16'h0000, 16'hABCD, 32'hABCD_0000};
      vecs[3] = '{2, 16'h5A5A, 16'hA5A5, 32'hA5A5_5A5A};

      rst = 1'b1; eoc_in = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
      do_reset();

      // Single scans with exact eoc->den and drdy->valid/den timing
      foreach (vecs[v]) begin
         mem[7'h16] = vecs[v].d0;
         mem[7'h03] = vecs[v].d1;
         lat = vecs[v].lat;
         snap_done = n_done;
         pulse_eoc();
         check("t1_no_den_c1", 64'(drp_den), 64'h0);
         tick();
         check("t1_den0", {drp_den, drp_dwe, drp_daddr}, {1'b1, 1'b0, 7'h16});
         tick(vecs[v].lat + 1);
         check("t1_valid0", {sample_valid, scan_done, drp_den, drp_daddr}, {2'b01, 1'b0, 1'b1, 7'h03});
         tick(vecs[v].lat + 1);
         check("t1_valid1", {sample_valid, scan_done}, {2'b10, 1'b1});
         check("t1_sample", 64'(sample), 64'(vecs[v].exp_sample));
         tick();
         check("t1_quiet", {sample_valid, scan_done, drp_den}, 4'b0);
         check("t1_done_once", 64'(n_done - snap_done), 64'd1);
      end

      // Two eocs during a scan coalesce into one follow-on scan
      lat = 4;
      snap_den = n_den; snap_done = n_done;
      pulse_eoc();
      tick(2);
      pulse_eoc();
      tick(4);
      pulse_eoc();
      tick(60);
      check("t2_den_count", 64'(n_den - snap_den), 64'd4);
      check("t2_scan_count", 64'(n_done - snap_done), 64'd2);

      // Host write raised mid-scan is serviced after the scan
      lat = 3;
      snap_done = n_done;
      pulse_eoc();
      tick(3);
      wr_req = 1'b1; wr_addr = 7'h40; wr_data = 16'h1234;
      wait_for(1, 40, "t3_wr_den", took);
      check("t3_scan_first", 64'(n_done - snap_done), 64'd1);
      check("t3_wr_bus", {drp_daddr, drp_di}, {7'h40, 16'h1234});
      tick(3);
      check("t3_ack_early", 64'(wr_ack), 64'h0);
      tick();
      check("t3_ack", 64'(wr_ack), 64'h1);
      wr_req = 1'b0;
      tick();
      check("t3_ack_pulse", {wr_ack, drp_den, drp_dwe, drp_di}, 64'h0);
      check("t3_mem", 64'(mem[7'h40]), 64'h1234);

      // Simultaneous wr_req and eoc from IDLE: write goes first
      mem[7'h16] = 16'h4321;
      mem[7'h03] = 16'h0042;
      eoc_in = 1'b1; wr_req = 1'b1; wr_addr = 7'h40; wr_data = 16'h00AA;
      tick();
      eoc_in = 1'b0;
      if (!drp_den) wait_for(0, 10, "t4_first_den", took);
      check("t4_first_is_write", {drp_dwe, drp_daddr, drp_di}, {1'b1, 7'h40, 16'h00AA});
      wait_for(3, 20, "t4_ack", took);
      wr_req = 1'b0;
      wait_for(0, 10, "t4_read_den", took);
      check("t4_read_after", {drp_dwe, drp_daddr}, {1'b0, 7'h16});
      wait_for(2, 30, "t4_done", took);
      check("t4_sample", 64'(sample), 64'h0042_4321);

      // Channel 0 never answers: timeout, channel 1 still read
      mem[7'h03] = 16'h0777;
      never_addr = 7'h16;
      snap_v0 = n_v0; snap_v1 = n_v1;
      pulse_eoc();
      wait_for(0, 10, "t5_den", took);
      tick(TIMEOUT);
      check("t5_err_not_early", 64'(timeout_err), 64'h0);
      wait_for(4, 3, "t5_err", took);
      wait_for(2, 30, "t5_done", took);
      check("t5_sample", 64'(sample), 64'h0777_4321);
      check("t5_v0_none", 64'(n_v0 - snap_v0), 64'd0);
      check("t5_v1_once", 64'(n_v1 - snap_v1), 64'd1);
      tick(3);
      check("t5_sticky", 64'(timeout_err), 64'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t5_cleared", 64'(timeout_err), 64'h0);
      never_addr = 7'h7F;

      // Reset during RD_WAIT, late drdy afterwards is ignored
      lat = 5;
      pulse_eoc();
      wait_for(0, 10, "t6_den", took);
      tick(2);
      rst = 1'b1;
      #1;
      check("t6_rst_ctl", 64'(ctl_outs()), 64'h0);
      check("t6_rst_sample", 64'(sample), 64'h0);
      tick();
      rst = 1'b0;
      snap_den = n_den; snap_v0 = n_v0; snap_v1 = n_v1;
      tick(8);
      check("t6_ignored", {32'(n_den - snap_den), 16'(n_v0 - snap_v0), 16'(n_v1 - snap_v1)}, 64'h0);
      pulse_eoc();
      wait_for(2, 40, "t6_done", took);
      check("t6_sample", 64'(sample), 64'h0777_4321);

      // Randomized traffic against the reference model
      do_reset();
      exp_ch = 0; exp_vec = '0; valid_due = 1'b0; out_busy = 1'b0;
      s_den = n_den; s_wden = n_wden; s_done = n_done; s_ack = n_ack; n_wr = 0;
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         eoc_in = ($urandom_range(0, 14) == 0);
         lat = $urandom_range(1, 5);
         if (wr_req) begin
            if (wr_ack) wr_req = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            wr_req  = 1'b1;
            wr_addr = 7'($urandom_range(32, 127));
            wr_data = 16'($urandom);
            n_wr++;
         end
      end
      eoc_in = 1'b0;
      if (wr_req) begin
         wait_for(3, 40, "rand_last_ack", took);
         wr_req = 1'b0;
      end
      tick(60);
      mon_en = 1'b0;
      check("rand_wr_dens", 64'(n_wden - s_wden), 64'(n_wr));
      check("rand_acks", 64'(n_ack - s_ack), 64'(n_wr));
      check("rand_reads_per_scan", 64'((n_den - s_den) - (n_wden - s_wden)), 64'(NUM_CH * (n_done - s_done)));
      check("rand_scans_seen", 64'(n_done - s_done > 0), 64'h1);
      check("rand_no_err", 64'(timeout_err), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
